// File: rtl/load_attr_fifo_scheduler.sv
// Shares one load-attribute FIFO between NUM_REQ requesters, tags entries with the requester ID and returns the oldest entry on load data return.
// Latency: grant, push and pop are combinational; a pushed entry is visible at the FIFO output no earlier than the next cycle.
// Backpressure: grants stop while the FIFO is full (unless it pops in the same cycle) or a fence drain is requested.
// Optional macro LOAD_ATTR_SCHED_FIXED_PRIORITY_EN: fixed lowest-index-wins priority instead of round-robin.
module load_attr_fifo_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int ATTR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OCC_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*ATTR_W-1:0] req_attr_i,
  output logic [NUM_REQ-1:0]       req_grant_o,
  input  logic                     rsp_valid_i,
  output logic                     rsp_attr_valid_o,
  output logic [ATTR_W-1:0]        rsp_attr_o,
  output logic [ID_W-1:0]          rsp_id_o,
  input  logic                     drain_req_i,
  output logic                     drained_o,
  output logic [OCC_W-1:0]         occupancy_o,
  output logic                     err_underflow_o,
  output logic                     fifo_potential_push_o,
  output logic                     fifo_push_o,
  output logic                     fifo_pop_o,
  output logic [ID_W+ATTR_W-1:0]   fifo_data_in_o,
  input  logic [ID_W+ATTR_W-1:0]   fifo_data_out_i,
  input  logic                     fifo_valid_i,
  input  logic                     fifo_full_i
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DRAINED
  } state_e;

  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  state_e           state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;

  logic [ID_W-1:0]  start_idx;
  logic [ID_W-1:0]  winner;
  logic             any_req;
  logic             pop_w;
  logic             push_w;
  logic             can_accept;

`ifdef LOAD_ATTR_SCHED_FIXED_PRIORITY_EN
  // Fixed priority: the search always starts at requester 0.
  assign start_idx = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  assign start_idx = rr_ptr_q;

  // Round-robin pointer moves to the requester after the one just granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push_w) begin
      rr_ptr_d = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Pop only when there is something to pop; the oldest entry is passed straight back.
  assign pop_w            = rsp_valid_i & fifo_valid_i;
  assign fifo_pop_o       = pop_w;
  assign rsp_attr_valid_o = fifo_valid_i;
  assign rsp_id_o         = fifo_data_out_i[ID_W+ATTR_W-1:ATTR_W];
  assign rsp_attr_o       = fifo_data_out_i[ATTR_W-1:0];

  // A full FIFO may still take a push in the same cycle it pops.
  assign can_accept = (state_q == ST_RUN) & ~drain_req_i & (~fifo_full_i | pop_w);

  // Search for the first requesting index starting at start_idx, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W:0] idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, start_idx} + (ID_W+1)'(k);
      if (idx >= NUM_REQ_X) begin
        idx = idx - NUM_REQ_X;
      end
      if (!any_req && req_valid_i[idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[ID_W-1:0];
      end
    end
  end

  // One-hot grant and the matching FIFO write.
  always_comb begin
    req_grant_o = '0;
    push_w      = 1'b0;
    if (can_accept && any_req) begin
      req_grant_o[winner] = 1'b1;
      push_w              = 1'b1;
    end
  end

  assign fifo_potential_push_o = push_w;
  assign fifo_push_o           = push_w;
  assign fifo_data_in_o        = {winner, req_attr_i[int'(winner)*ATTR_W +: ATTR_W]};

  // Occupancy tracking and sticky underflow flag.
  always_comb begin
    occ_d = occ_q + {{(OCC_W-1){1'b0}}, push_w} - {{(OCC_W-1){1'b0}}, pop_w};
    err_d = err_q | (rsp_valid_i & ~fifo_valid_i);
  end

  // Drain FSM next state: a pop of the last entry lets DRAIN finish one cycle early.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (drain_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req_i) begin
          state_d = ST_RUN;
        end else if ((occ_q == '0) || ((occ_q == OCC_ONE) && pop_w)) begin
          state_d = ST_DRAINED;
        end
      end
      ST_DRAINED: begin
        if (!drain_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, occupancy and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  assign drained_o       = (state_q == ST_DRAINED);
  assign occupancy_o     = occ_q;
  assign err_underflow_o = err_q;

`ifndef SYNTHESIS
  // Simulation-only sanity checks on grant shape and occupancy tracking.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_grant_o));
      assert (occ_q <= OCC_W'(FIFO_DEPTH));
      assert (fifo_valid_i == (occ_q != '0));
    end
  end
`endif

endmodule

// File: tb/tb_load_attr_fifo_scheduler.sv
// Testbench for load_attr_fifo_scheduler: behavioural FIFO, reference model and scoreboard.
// Latency: one step per clock; inputs change #1 after posedge, outputs are compared at negedge.
// Backpressure: the behavioural FIFO reports full at FIFO_DEPTH entries.
module tb_load_attr_fifo_scheduler;

  localparam int N     = 2;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int DW    = IW + AW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_attr;
  logic [N-1:0]    req_grant;
  logic            rsp_valid;
  logic            rsp_attr_valid;
  logic [AW-1:0]   rsp_attr;
  logic [IW-1:0]   rsp_id;
  logic            drain_req;
  logic            drained;
  logic [OW-1:0]   occupancy;
  logic            err_underflow;
  logic            fifo_potential_push;
  logic            fifo_push;
  logic            fifo_pop;
  logic [DW-1:0]   fifo_data_in;
  logic [DW-1:0]   fifo_data_out;
  logic            fifo_valid;
  logic            fifo_full;

  always #5 clk = ~clk;

  load_attr_fifo_scheduler #(.NUM_REQ(N), .ATTR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid_i          (req_valid),
    .req_attr_i           (req_attr),
    .req_grant_o          (req_grant),
    .rsp_valid_i          (rsp_valid),
    .rsp_attr_valid_o     (rsp_attr_valid),
    .rsp_attr_o           (rsp_attr),
    .rsp_id_o             (rsp_id),
    .drain_req_i          (drain_req),
    .drained_o            (drained),
    .occupancy_o          (occupancy),
    .err_underflow_o      (err_underflow),
    .fifo_potential_push_o(fifo_potential_push),
    .fifo_push_o          (fifo_push),
    .fifo_pop_o           (fifo_pop),
    .fifo_data_in_o       (fifo_data_in),
    .fifo_data_out_i      (fifo_data_out),
    .fifo_valid_i         (fifo_valid),
    .fifo_full_i          (fifo_full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO attached to the DUT, plus decisions latched at negedge.
  logic [DW-1:0] env_q[$];
  logic          env_clr, env_push, env_pop;
  logic [DW-1:0] env_din;

  // Reference model: drain mode 0=running 1=draining 2=drained.
  int            m_occ, m_rr, m_mode;
  bit            m_err;
  logic [DW-1:0] sb[$];

  // Monitor: every returned entry must be the oldest one the model predicted.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_attr_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        chk("rsp_id", longint'(rsp_id), longint'(e[DW-1:AW]));
        chk("rsp_attr", longint'(rsp_attr), longint'(e[AW-1:0]));
      end
    end
  end

  task automatic step(input logic [N-1:0] rv, input logic [N*AW-1:0] ra,
                      input logic rsp, input logic drq, input logic r);
    int            w;
    bit            exp_pop, can_acc;
    logic [N-1:0]  exp_grant;
    @(posedge clk);
    #1;
    if (env_clr) begin
      env_q.delete();
    end else begin
      if (env_pop && env_q.size() > 0) void'(env_q.pop_front());
      if (env_push) env_q.push_back(env_din);
    end
    fifo_valid    = (env_q.size() != 0);
    fifo_full     = (env_q.size() >= DEPTH);
    fifo_data_out = (env_q.size() != 0) ? env_q[0] : '0;
    rst       = r;
    req_valid = rv;
    req_attr  = ra;
    rsp_valid = rsp;
    drain_req = drq;
    @(negedge clk);
    env_clr  = r;
    env_push = fifo_push;
    env_pop  = fifo_pop;
    env_din  = fifo_data_in;
    if (r) begin
      m_occ = 0; m_rr = 0; m_mode = 0; m_err = 0;
      sb.delete();
    end else begin
      // Outputs depending only on held state.
      chk("occupancy", longint'(occupancy), longint'(m_occ));
      chk("drained", longint'(drained), longint'(m_mode == 2));
      chk("err_underflow", longint'(err_underflow), longint'(m_err));
      chk("rsp_attr_valid", longint'(rsp_attr_valid), longint'(m_occ != 0));
      // Expected grant from the arbitration rule.
      exp_pop = rsp && (m_occ > 0);
      can_acc = (m_mode == 0) && !drq && ((m_occ < DEPTH) || exp_pop);
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
`ifdef LOAD_ATTR_SCHED_FIXED_PRIORITY_EN
        i = k;
`else
        i = (m_rr + k) % N;
`endif
        if (w < 0 && rv[i]) w = i;
      end
      exp_grant = '0;
      if (can_acc && w >= 0) exp_grant[w] = 1'b1;
      chk("req_grant", longint'(req_grant), longint'(exp_grant));
      chk("fifo_push", longint'(fifo_push), longint'(exp_grant != 0));
      chk("fifo_potential_push", longint'(fifo_potential_push), longint'(exp_grant != 0));
      chk("fifo_pop", longint'(fifo_pop), longint'(exp_pop));
      if (exp_grant != 0) begin
        logic [DW-1:0] e;
        e = {IW'(w), ra[w*AW +: AW]};
        chk("fifo_data_in", longint'(fifo_data_in), longint'(e));
        sb.push_back(e);
        m_rr = (w + 1) % N;
      end
      // Drain mode transitions.
      case (m_mode)
        0: if (drq) m_mode = 1;
        1: if (!drq) m_mode = 0;
           else if (m_occ == 0 || (m_occ == 1 && exp_pop)) m_mode = 2;
        default: if (!drq) m_mode = 0;
      endcase
      if (rsp && m_occ == 0) m_err = 1;
      m_occ = m_occ + (exp_grant != 0 ? 1 : 0) - (exp_pop ? 1 : 0);
    end
  endtask

  initial begin
    logic [N*AW-1:0] a;
    bit              drq;
    rst = 1'b1; req_valid = '0; req_attr = '0; rsp_valid = 1'b0; drain_req = 1'b0;
    fifo_valid = 1'b0; fifo_full = 1'b0; fifo_data_out = '0;
    env_clr = 1'b1; env_push = 1'b0; env_pop = 1'b0; env_din = '0;
    m_occ = 0; m_rr = 0; m_mode = 0; m_err = 0;
    step('0, '0, 0, 0, 1);
    step('0, '0, 0, 0, 1);
    // Reset state.
    step('0, '0, 0, 0, 0);
    // Requester 1 alone fills the FIFO, then four returns drain it.
    for (int c = 0; c < 5; c++) step(2'b10, {8'hA5, 8'h00}, 0, 0, 0);
    for (int c = 0; c < 4; c++) step(2'b00, '0, 1, 0, 0);
    // Both requesters with returns held high: alternating grants.
    for (int c = 0; c < 6; c++) step(2'b11, {8'h22, 8'h11}, 1, 0, 0);
    for (int c = 0; c < 3; c++) step(2'b00, '0, 1, 0, 0);
    // Fill to full, then push and pop together while full.
    for (int c = 0; c < 4; c++) step(2'b01, {8'h00, 8'h40 + 8'(c)}, 0, 0, 0);
    step(2'b01, {8'h00, 8'h5C}, 1, 0, 0);
    step(2'b01, {8'h00, 8'h5D}, 0, 0, 0);
    for (int c = 0; c < 4; c++) step(2'b00, '0, 1, 0, 0);
    // Drain handshake with two entries in flight.
    step(2'b01, {8'h00, 8'h71}, 0, 0, 0);
    step(2'b10, {8'h72, 8'h00}, 0, 0, 0);
    step(2'b11, {8'h74, 8'h73}, 0, 1, 0);
    step(2'b11, {8'h74, 8'h73}, 1, 1, 0);
    step(2'b00, '0, 1, 1, 0);
    step(2'b11, {8'h74, 8'h73}, 0, 1, 0);
    step(2'b00, '0, 0, 0, 0);
    step(2'b11, {8'h76, 8'h75}, 0, 0, 0);
    step(2'b00, '0, 1, 0, 0);
    step(2'b00, '0, 1, 0, 0);
    // Underflow: return with nothing stored, flag stays set.
    step(2'b00, '0, 1, 0, 0);
    step(2'b00, '0, 0, 0, 0);
    step(2'b00, '0, 0, 0, 0);
    // Three entries via requester 0, enter drain, then reset mid-operation.
    for (int c = 0; c < 3; c++) step(2'b01, {8'h00, 8'h90 + 8'(c)}, 0, 0, 0);
    step(2'b00, '0, 0, 1, 0);
    step(2'b00, '0, 0, 1, 1);
    step(2'b11, {8'hB1, 8'hB0}, 0, 0, 0);
    step(2'b11, {8'hB3, 8'hB2}, 0, 0, 0);
    // Randomized traffic with occasional drains and resets.
    drq = 0;
    for (int c = 0; c < 600; c++) begin
      a = N*AW'($urandom);
      if ($urandom_range(0, 19) == 0) drq = !drq;
      step(N'($urandom_range(0, (1 << N) - 1)), a,
           ($urandom_range(0, 9) < 4), drq, ($urandom_range(0, 199) == 0));
    end
    for (int c = 0; c < 6; c++) step('0, '0, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
